// File: rtl/mtf_pkg.sv
// Shared types for the move-to-front decoder: symbol kinds, the deframer
// symbol layout, and the one-hot to position helper.
package mtf_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int HISTORY_L_DEF = 4;

  typedef enum logic {
    SYM_IDX = 1'b0,
    SYM_LIT = 1'b1
  } sym_kind_e;

  // Symbol as delivered by the deframer, at the default geometry.
  typedef struct packed {
    sym_kind_e                          kind;
    logic [$clog2(HISTORY_L_DEF)-1:0]   idx;
    logic [DATA_W_DEF-1:0]              lit;
  } mtf_sym_t;

  // Position of the set bit in a one-hot word; all-zero input gives 0.
  function automatic int unsigned onehot_dec(input logic [31:0] oh);
    int unsigned pos;
    pos = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) pos = pos | i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/mtf_history_table.sv
// Most-recent-first unique history: move-to-front on update plus a
// parallel literal compare against every valid entry.
module mtf_history_table
  import mtf_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int HISTORY_L   = 4,
  localparam int HISTORY_L_W = $clog2(HISTORY_L)
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic                              upd,
  input  logic [HISTORY_L_W-1:0]            shift_pos,
  input  logic                              shift_all,
  input  logic [DATA_W-1:0]                 new_val,
  input  logic [DATA_W-1:0]                 cmp_val,
  output logic [HISTORY_L-1:0][DATA_W-1:0]  entries,
  output logic [HISTORY_L-1:0]              valid,
  output logic [HISTORY_L-1:0]              match_oh
);

  always_comb begin
    match_oh = '0;
    for (int i = 0; i < HISTORY_L; i++) begin
      match_oh[i] = valid[i] && (entries[i] == cmp_val);
    end
  end

  // Entries above shift_pos keep their value unless a fresh value is inserted.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      entries <= '0;
      valid   <= '0;
    end else if (upd) begin
      for (int i = 1; i < HISTORY_L; i++) begin
        if (shift_all || (i <= int'(shift_pos))) entries[i] <= entries[i-1];
      end
      entries[0] <= new_val;
      if (shift_all) valid <= {valid[HISTORY_L-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mtf_decoder.sv
// Move-to-front decoder: turns index/literal symbols back into data values
// while keeping a history in lock-step with the encoder.
module mtf_decoder
  import mtf_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int HISTORY_L   = 4,
  localparam int HISTORY_L_W = $clog2(HISTORY_L)
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    sym_valid_in,
  output logic                    sym_ready_out,
  input  logic                    sym_is_lit_in,
  input  logic [HISTORY_L_W-1:0]  sym_idx_in,
  input  logic [DATA_W-1:0]       sym_lit_in,
  output logic                    data_valid_out,
  input  logic                    data_ready_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    err_out,
  output logic [HISTORY_L-1:0]    hist_valid_out
);

  logic [HISTORY_L-1:0][DATA_W-1:0] entries;
  logic [HISTORY_L-1:0]             valid;
  logic [HISTORY_L-1:0]             match_oh;
  logic [HISTORY_L_W-1:0]           lit_pos;
  logic                             accept;
  logic                             upd;
  logic                             shift_all;
  logic [HISTORY_L_W-1:0]           shift_pos;
  logic [DATA_W-1:0]                new_val;
  logic                             dec_ok;
  logic                             dec_err;

  assign sym_ready_out  = ~data_valid_out | data_ready_in;
  assign accept         = sym_valid_in & sym_ready_out;
  assign hist_valid_out = valid;
  assign lit_pos        = HISTORY_L_W'(onehot_dec(32'(match_oh)));

  mtf_history_table #(
    .DATA_W    (DATA_W),
    .HISTORY_L (HISTORY_L)
  ) u_hist (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .upd       (upd),
    .shift_pos (shift_pos),
    .shift_all (shift_all),
    .new_val   (new_val),
    .cmp_val   (sym_lit_in),
    .entries   (entries),
    .valid     (valid),
    .match_oh  (match_oh)
  );

  // A literal already in the list is handled exactly like an index to it.
  always_comb begin
    upd       = 1'b0;
    shift_all = 1'b0;
    shift_pos = '0;
    new_val   = '0;
    dec_ok    = 1'b0;
    dec_err   = 1'b0;
    if (accept) begin
      if (sym_kind_e'(sym_is_lit_in) == SYM_LIT) begin
        upd     = 1'b1;
        dec_ok  = 1'b1;
        new_val = sym_lit_in;
        if (|match_oh) shift_pos = lit_pos;
        else           shift_all = 1'b1;
      end else if ((int'(sym_idx_in) < HISTORY_L) && valid[sym_idx_in]) begin
        upd       = 1'b1;
        dec_ok    = 1'b1;
        new_val   = entries[sym_idx_in];
        shift_pos = sym_idx_in;
      end else begin
        dec_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      data_valid_out <= 1'b0;
      data_out       <= '0;
      err_out        <= 1'b0;
    end else begin
      err_out <= dec_err;
      if (dec_ok) begin
        data_valid_out <= 1'b1;
        data_out       <= new_val;
      end else if (data_ready_in) begin
        data_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtf_decoder.sv
// Self-checking bench for mtf_decoder: a reference history model feeds a
// queue of expected outputs that is drained as the consumer takes data.
module tb_mtf_decoder;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       sym_valid_in;
  logic       sym_ready_out;
  logic       sym_is_lit_in;
  logic [1:0] sym_idx_in;
  logic [7:0] sym_lit_in;
  logic       data_valid_out;
  logic       data_ready_in;
  logic [7:0] data_out;
  logic       err_out;
  logic [3:0] hist_valid_out;

  mtf_decoder #(.DATA_W(8), .HISTORY_L(4)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .sym_valid_in   (sym_valid_in),
    .sym_ready_out  (sym_ready_out),
    .sym_is_lit_in  (sym_is_lit_in),
    .sym_idx_in     (sym_idx_in),
    .sym_lit_in     (sym_lit_in),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .data_out       (data_out),
    .err_out        (err_out),
    .hist_valid_out (hist_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_ent [4];
  logic [3:0] m_val;
  logic       m_out_valid;
  logic       m_err;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_move(input int p, input logic [7:0] v);
    for (int i = p; i > 0; i--) m_ent[i] = m_ent[i-1];
    m_ent[0] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ent[i] = 8'h00;
    m_val       = 4'b0000;
    m_out_valid = 1'b0;
    m_err       = 1'b0;
    exp_q.delete();
  endtask

  task automatic post_checks();
    chk("data_valid", 32'(data_valid_out), 32'(m_out_valid));
    chk("err", 32'(err_out), 32'(m_err));
    chk("hist_valid", 32'(hist_valid_out), 32'(m_val));
    if (m_out_valid && exp_q.size() > 0) chk("data", 32'(data_out), 32'(exp_q[0]));
  endtask

  // One clock: drive at negedge, advance the model, check after posedge.
  task automatic tick(input logic v, input logic lit, input logic [1:0] idx,
                      input logic [7:0] val, input logic rdy);
    logic exp_ready;
    logic acc;
    logic ok;
    int   p;
    @(negedge clk_in);
    sym_valid_in  = v;
    sym_is_lit_in = lit;
    sym_idx_in    = idx;
    sym_lit_in    = val;
    data_ready_in = rdy;
    #1;
    exp_ready = ~m_out_valid | rdy;
    chk("sym_ready", 32'(sym_ready_out), 32'(exp_ready));
    acc = v & exp_ready;
    if (m_out_valid && rdy) begin
      m_out_valid = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    m_err = 1'b0;
    ok    = 1'b0;
    if (acc) begin
      if (lit) begin
        p = -1;
        for (int i = 0; i < 4; i++) if (m_val[i] && m_ent[i] == val) p = i;
        if (p >= 0) model_move(p, val);
        else begin
          model_move(3, val);
          m_val = {m_val[2:0], 1'b1};
        end
        exp_q.push_back(val);
        ok = 1'b1;
      end else if (m_val[idx]) begin
        exp_q.push_back(m_ent[idx]);
        model_move(int'(idx), m_ent[idx]);
        ok = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (ok) m_out_valid = 1'b1;
    @(posedge clk_in);
    #1;
    post_checks();
  endtask

  task automatic send_lit(input logic [7:0] v);
    tick(1'b1, 1'b1, 2'd0, v, 1'b1);
  endtask

  task automatic send_idx(input logic [1:0] i);
    tick(1'b1, 1'b0, i, 8'h5A, 1'b1);
  endtask

  task automatic do_reset(input logic sym_busy);
    @(negedge clk_in);
    reset_in      = 1'b1;
    sym_valid_in  = sym_busy;
    sym_is_lit_in = 1'b1;
    sym_lit_in    = 8'hF0;
    @(posedge clk_in);
    #1;
    model_reset();
    chk("rst_data_valid", 32'(data_valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_hist_valid", 32'(hist_valid_out), 32'd0);
    @(negedge clk_in);
    reset_in     = 1'b0;
    sym_valid_in = 1'b0;
  endtask

  initial begin
    reset_in      = 1'b1;
    sym_valid_in  = 1'b0;
    sym_is_lit_in = 1'b0;
    sym_idx_in    = 2'd0;
    sym_lit_in    = 8'h00;
    data_ready_in = 1'b1;
    model_reset();
    do_reset(1'b0);

    // Fresh literals, index move-to-front, duplicate literal
    send_lit(8'h11); send_lit(8'h22); send_lit(8'h33);
    chk("tbl_valid_0111", 32'(hist_valid_out), 32'h7);
    send_idx(2'd2);
    chk("idx2_value", 32'(data_out), 32'h11);
    send_idx(2'd0);
    send_lit(8'h22);
    chk("dup_not_inserted", 32'(hist_valid_out), 32'h7);
    send_idx(2'd0); send_idx(2'd1); send_idx(2'd2);

    // Overflow discards the oldest entry
    do_reset(1'b0);
    send_lit(8'hAA); send_lit(8'hBB); send_lit(8'hCC); send_lit(8'hDD); send_lit(8'hEE);
    chk("full_valid", 32'(hist_valid_out), 32'hF);
    send_idx(2'd3);
    chk("idx3_full", 32'(data_out), 32'hBB);
    for (int i = 0; i < 4; i++) send_idx(2'(i));

    // Invalid index reference
    do_reset(1'b0);
    send_lit(8'h01); send_lit(8'h02);
    send_idx(2'd3);
    tick(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    send_idx(2'd1);
    send_idx(2'd2);
    send_idx(2'd0);

    // Back-pressure: hold for 5 cycles, then release with a same-cycle accept
    tick(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 2'd0, 8'h55, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 2'd0, 8'h66, 1'b0);
    tick(1'b1, 1'b1, 2'd0, 8'h66, 1'b1);
    tick(1'b1, 1'b0, 2'd1, 8'h00, 1'b1);
    do_reset(1'b1);

    // Randomised traffic over a small alphabet to exercise matches
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)),
           1'($urandom_range(0, 3) != 0));
    end
    tick(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mtf_decoder.md
Name: mtf_decoder

Overview:
- Move-to-front decoder: the receive-side counterpart of the unique-history encoder front end.
- Consumes a symbol stream where each symbol is either an index into the recent-unique-value list or a literal value, and reconstructs the original data stream.
- Maintains its own unique most-recent-first history, updated identically to the encoder side, so both ends stay in lock-step.
- Sits between the compressed-stream deframer and the downstream data consumer; valid/ready on both sides.

Parameters:
- DATA_W, 8, width of data values and literals.
- HISTORY_L, 4, number of history entries (>=2).
- HISTORY_L_W, $clog2(HISTORY_L), index width (localparam, derived).

Ports:
- clk_in  input  1  clock, all state on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- sym_valid_in  input  1  symbol present.
- sym_ready_out  output  1  decoder accepts symbol this cycle.
- sym_is_lit_in  input  1  1 = literal symbol, 0 = index symbol.
- sym_idx_in  input  HISTORY_L_W  history position for index symbols (0 = most recent).
- sym_lit_in  input  DATA_W  literal value for literal symbols.
- data_valid_out  output  1  decoded value present.
- data_ready_in  input  1  consumer takes data_out this cycle.
- data_out  output  DATA_W  decoded value.
- err_out  output  1  one-cycle pulse: index symbol referenced an invalid entry.
- hist_valid_out  output  HISTORY_L  valid bit per history entry (debug/verification).

Behaviour:
- Reset, with priority over everything: data_valid_out=0, data_out=0, err_out=0, all history entries=0, hist_valid_out=0.
- Accept condition: sym_valid_in & sym_ready_out.
  - sym_ready_out = ~data_valid_out | data_ready_in. Combinational, no dependency on sym_valid_in.
- Latency: accepted symbol -> data_valid_out=1 with the decoded value on the next cycle. Throughput is 1 symbol/cycle.
- Output hold: data_out and data_valid_out hold stable while data_valid_out & ~data_ready_in. If the output is drained with no new accept, data_valid_out falls to 0.
- Index symbol, idx = sym_idx_in:
  - Entry idx valid: decoded value = entry[idx]. Entries 0..idx-1 shift up by one, entry[0] <= value. Valid vector unchanged.
  - idx=0: no shift.
  - Entry idx invalid, or idx >= HISTORY_L: symbol consumed, err_out=1 next cycle, no output produced (data_valid_out=0 unless a held value is still pending), history unchanged.
- Literal symbol, value = sym_lit_in:
  - Compare against all valid entries; at most one can match (uniqueness invariant).
  - Match at position p: treated exactly as index p. Move to front, valid unchanged.
  - No match: all entries shift up, entry[0] <= value, valid <= (valid<<1)|1. The oldest entry is discarded when full.
  - Decoded value = literal.
- History update happens on the same edge the symbol is accepted. The next symbol decodes against the updated list, so back-to-back symbols have no hazard.
- Invariant: all valid entries are pairwise distinct, and valid bits form a contiguous run from bit 0.
- err_out is a single-cycle pulse per offending symbol; it is never sticky.
- sym_* inputs are ignored when not accepted.

Decomposition:
- Shared package mtf_pkg:
  - sym_kind enum {SYM_IDX=0, SYM_LIT=1}.
  - A packed symbol struct template (kind, idx, lit) for the deframer interface.
- Sub-module mtf_history_table holds the entries and valid vector. Interface: update strobe, shift-limit position, shift-all flag, new value; it exposes entries, valid and a literal-match one-hot.
- The one-hot -> position conversion uses the existing onehot_dec.
- mtf_decoder top contains the handshake, output register and error logic.

Test Plan (DATA_W=8, HISTORY_L=4, data_ready_in=1 unless stated):
- Reset, then literals 0x11, 0x22, 0x33 -> data_out 0x11, 0x22, 0x33 on consecutive cycles; table [0x33,0x22,0x11,-], hist_valid_out=4'b0111.
- Then index 2 -> data_out 0x11, table [0x11,0x33,0x22,-]. Then index 0 -> 0x11, table unchanged.
- Literal 0x22 while table is [0x11,0x33,0x22] -> data_out 0x22, table [0x22,0x11,0x33], valid still 4'b0111. Duplicate is not inserted.
- Literals 0xAA, 0xBB, 0xCC, 0xDD, 0xEE from reset -> table [0xEE,0xDD,0xCC,0xBB], valid 4'b1111. Then index 3 -> 0xBB. 0xAA is gone.
- After 2 literals (valid 4'b0011), index 3 -> err_out=1 for exactly one cycle, no data_valid_out, table unchanged. Next index 1 decodes correctly.
- Hold data_ready_in=0 with data_valid_out=1 -> sym_ready_out=0 and data_out stable for 5 cycles. Release -> value taken, next symbol accepted the same cycle. Then assert reset_in mid-stream -> next cycle data_valid_out=0, hist_valid_out=0.
